bcd_to_binary: RTL

- Sequential reverse double-dabble converter: takes a 4-digit packed BCD value (thous/hundreds/tens/ones, 0000–9999) and produces its binary equivalent on a 15-bit bus.
- Serves as the inverse of the score display path: BCD values entered by the player or read from a BCD register (e.g. target score or high score) become binary for comparison with the game's 15-bit score counter.
- One shift-and-correct step per clock. Start/busy/done handshake.

---
 rtl/bcd_to_binary.sv | 105 ++++++++++
 1 files changed

// File: rtl/bcd_to_binary.sv
// rtl/bcd_to_binary.sv - sequential reverse double-dabble converter, 4-digit packed BCD to binary
// One shift-and-correct step per clock; start/busy/done handshake with an invalid-digit flag.
module bcd_to_binary #(
    parameter int OUT_W   = 15,
    parameter int N_SHIFT = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       thous,
    input  logic [3:0]       hundreds,
    input  logic [3:0]       tens,
    input  logic [3:0]       ones,
    output logic [OUT_W-1:0] binary,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int WORK_W = 14;
    localparam int CNT_W  = $clog2(N_SHIFT + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_SHIFT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q;
    logic [15:0]         bcd_q;
    logic [15:0]         bcd_d;
    logic [WORK_W-1:0]   work_q;
    logic [WORK_W-1:0]   work_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [OUT_W-1:0]    binary_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [29:0]         shifted;
    logic                digit_bad;

    assign digit_bad = (thous > 4'd9) || (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);

    // A nibble that picked up the low bit of its upper neighbour is worth 5, not 8: take 3 back off.
    always_comb begin
        shifted = {bcd_q, work_q} >> 1;
        work_d  = shifted[WORK_W-1:0];
        bcd_d   = shifted[29:WORK_W];
        for (int i = 0; i < 4; i++) begin
            if (bcd_d[4*i+3]) begin
                bcd_d[4*i +: 4] = bcd_d[4*i +: 4] - 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            bcd_q    <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            binary_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bcd_q  <= {thous, hundreds, tens, ones};
                        work_q <= '0;
                        cnt_q  <= '0;
                        err_q  <= digit_bad;
                        if (digit_bad) begin
                            binary_q <= '0;
                            done_q   <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    bcd_q  <= bcd_d;
                    work_q <= work_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        binary_q <= OUT_W'(work_d);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign binary = binary_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule
